// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode selectors
// and the width of a fill-level counter that must be able to hold DEPTH itself.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int level_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, asynchronous read.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR       = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]       raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, standard or
// first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR       = 4,
  parameter int FWFT       = FIFO_STD,
  parameter int AF_LEVEL   = (1 << ADDR) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR:0]         level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR;
  localparam int LW    = level_width(ADDR);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_af_range
    $error("sync_fifo: AF_LEVEL must lie in 1..DEPTH-1");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_range
    $error("sync_fifo: AE_LEVEL must lie in 0..DEPTH-1");
  end
  if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_mode_range
    $error("sync_fifo: FWFT must be FIFO_STD or FIFO_FWFT");
  end

  logic [ADDR-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]         level_q;
  logic [DATA_WIDTH-1:0] dout_q, mem_rdata;
  logic                  wr_acc, rd_acc, mem_we;

  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LW'(AF_LEVEL));
  assign almost_empty = (level_q <= LW'(AE_LEVEL));
  assign level        = level_q;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // when it is also being read.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign mem_we = wr_acc & rst_n & ~flush;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR      (ADDR)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      dout_q    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR'(1);
        dout_q <= mem_rdata;
      end
      if (wr_acc && !rd_acc)      level_q <= level_q + LW'(1);
      else if (rd_acc && !wr_acc) level_q <= level_q - LW'(1);
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && empty)   underflow <= 1'b1;
    end
  end

  // FWFT presents the head word straight from the memory read mux.
  assign dout = (FWFT == FIFO_FWFT) ? mem_rdata : dout_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench: standard and FWFT instances share stimulus; a monitor pops
// expected words whenever either instance presents read data.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout_s, dout_f;
  logic       full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [4:0] level_s, level_f;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  logic [7:0] exp_s[$];
  logic [7:0] exp_f[$];

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .ADDR(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .level(level_s), .overflow(ovf_s), .underflow(udf_s)
  );

  sync_fifo #(.DATA_WIDTH(8), .ADDR(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .level(level_f), .overflow(ovf_f), .underflow(udf_f)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_state(input string tag, input int lvl, input logic ovf, input logic udf);
    checkOutput({tag, ".level"},     32'(level_s), lvl);
    checkOutput({tag, ".full"},      32'(full_s),  32'(lvl == 16));
    checkOutput({tag, ".empty"},     32'(empty_s), 32'(lvl == 0));
    checkOutput({tag, ".afull"},     32'(af_s),    32'(lvl >= 14));
    checkOutput({tag, ".aempty"},    32'(ae_s),    32'(lvl <= 2));
    checkOutput({tag, ".overflow"},  32'(ovf_s),   32'(ovf));
    checkOutput({tag, ".underflow"}, 32'(udf_s),   32'(udf));
    checkOutput({tag, ".fwft_level"}, 32'(level_f), lvl);
    checkOutput({tag, ".fwft_empty"}, 32'(empty_f), 32'(lvl == 0));
  endtask

  // Drives one cycle of stimulus, predicts acceptance and queues written words.
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d, input logic f);
    logic rd_ok, wr_ok;
    wr_en = w;
    rd_en = r;
    din   = d;
    flush = f;
    rd_ok = r && (model_cnt > 0);
    wr_ok = w && ((model_cnt < 16) || rd_ok);
    if (!f) begin
      if (wr_ok) begin
        exp_s.push_back(d);
        exp_f.push_back(d);
      end
      model_cnt = model_cnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    if (f) begin
      model_cnt = 0;
      exp_s.delete();
      exp_f.delete();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    din   = 8'h00;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    model_cnt = 0;
    exp_s.delete();
    exp_f.delete();
    rst_n = 1'b1;
  endtask

  // Standard mode data shows one edge after an accepted read; FWFT shows the
  // head word while rd_en is presented against a non-empty FIFO.
  task automatic monitor();
    logic pend_s = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_s) begin
        if (exp_s.size() == 0) checkOutput("std_unexpected_read", 32'(dout_s), 32'hDEAD);
        else checkOutput("std_dout", 32'(dout_s), 32'(exp_s.pop_front()));
        pend_s = 1'b0;
      end
      if (rst_n && !flush && rd_en && !empty_s) pend_s = 1'b1;
      if (rst_n && !flush && rd_en && !empty_f) begin
        if (exp_f.size() == 0) checkOutput("fwft_unexpected_read", 32'(dout_f), 32'hDEAD);
        else checkOutput("fwft_dout", 32'(dout_f), 32'(exp_f.pop_front()));
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    reset_dut();
    check_state("reset", 0, 1'b0, 1'b0);
    checkOutput("reset_dout", 32'(dout_s), 32'h00);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
      check_state("fill", i + 1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0);
    check_state("overflow", 16, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      check_state("drain", 15 - i, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    check_state("underflow", 0, 1'b1, 1'b1);
    checkOutput("dout_hold_underflow", 32'(dout_s), 32'h0F);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check_state("flush_clear", 0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0);
    checkOutput("fwft_show", 32'(dout_f), 32'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("fwft_hold", 32'(dout_f), 32'hA5);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    check_state("fwft_pop", 0, 1'b0, 1'b0);

    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + rep * 16 + i), 1'b0);
      check_state("wrap_fill", 10, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      check_state("wrap_drain", 0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    check_state("simul_full_pre", 16, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0);
    check_state("simul_full", 16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    check_state("simul_drain", 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
    check_state("simul_empty", 1, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    check_state("pre_flush", 7, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h99, 1'b1);
    check_state("flush_mid", 0, 1'b0, 1'b0);
    checkOutput("flush_dout_hold", 32'(dout_s), 32'hEE);
    applyStimulus(1'b1, 1'b0, 8'h12, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    check_state("post_flush", 0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    check_state("pre_reset", 5, 1'b0, 1'b0);
    reset_dut();
    check_state("reset_mid", 0, 1'b0, 1'b0);
    checkOutput("reset_mid_dout", 32'(dout_s), 32'h00);

    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("std_queue_drained", 32'(exp_s.size()), 0);
    checkOutput("fwft_queue_drained", 32'(exp_f.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO, the single-clock-domain successor to the team's dual-clock FIFO, used wherever the AHB-Lite and SPI paths share one clock and need buffering without synchroniser cost. Adds fill-level output, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, synchronous flush, and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 8, width of each data word
- ADDR, 4, address bits; DEPTH = 2^ADDR entries
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous clear of contents and pointers
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read request (FWFT: pop/acknowledge)
- dout  out  DATA_WIDTH  read data
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- level  out  ADDR+1  current number of stored words, 0..DEPTH
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

## Operation
- Reset (rst_n low at an edge): pointers, level = 0, dout = 0, overflow = underflow = 0; empty = 1, almost_empty = 1, full = almost_full = 0.
- wr_acc = wr_en & (~full | rd_acc); rd_acc = rd_en & ~empty.
- Write: mem[wr_ptr] <= din, wr_ptr + 1 (mod DEPTH, natural wrap of ADDR-bit pointer).
- Read: rd_ptr + 1 mod DEPTH. Standard mode: dout <= mem[rd_ptr] on rd_acc, else dout holds. FWFT: dout = mem[rd_ptr] combinationally whenever ~empty; rd_en pops the displayed word; dout undefined-but-stable content is not checked when empty.
- level: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither. Flags derive combinationally from level.
- Full with wr_en & rd_en: both accepted, level stays DEPTH.
- Empty with wr_en & rd_en: write accepted, read rejected, underflow set, level → 1.
- overflow set on wr_en & ~wr_acc; underflow set on rd_en & empty. Both cleared only by reset or flush.
- flush: same effect as reset except dout holds its value. Reset has priority over flush; flush overrides any same-cycle wr_en/rd_en (nothing written or read).
- AF_LEVEL, AE_LEVEL must lie in 1..DEPTH−1 and 0..DEPTH−1; out-of-range is a parameter error.

## Timing
- Write at edge N: level, empty, flags updated after edge N; word readable at edge N+1.
- Standard mode: rd_en sampled at edge N, data valid on dout after edge N (one-cycle read latency).
- FWFT: first word appears on dout the cycle after the write edge (zero extra latency); next word appears after the popping edge.
- No combinational path from din to dout; in FWFT, path rd_ptr → dout is through memory read mux only.
- Reset/flush take effect at the sampling edge; outputs valid after it.

## Structure
- Shared package fifo_pkg: mode constants FIFO_STD = 0, FIFO_FWFT = 1; level width helper (ADDR+1). Reused by future FIFO variants.
- Sub-module fifo_mem: DEPTH×DATA_WIDTH register file, synchronous write, asynchronous read; top holds pointers, level counter, flags.

## Test plan
- Reset then 16 writes 0x00..0x0F (ADDR=4) -> full=1 at level 16, almost_full from level 14, 17th write sets overflow, level stays 16.
- Standard mode: drain 16 reads -> dout 0x00..0x0F each one cycle after rd_en, empty=1 after last, extra read sets underflow, dout holds 0x0F.
- FWFT: write 0xA5 -> dout=0xA5 next cycle without rd_en; rd_en pops, empty=1.
- Wrap-around: 10 writes, 10 reads, repeat 3 times -> data order preserved, level returns 0, no error flags.
- Simultaneous: at full, wr_en+rd_en -> level stays 16, written word read out in order; at empty, both -> level 1, underflow=1.
- Mid-operation: level 7, assert flush with wr_en -> level 0, empty=1, flags cleared, dout holds; rst_n low at level 5 -> all outputs reset values.
